// File: rtl/riscv_soft_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction fetch and data access.
// Define RISCV_SOFT_MEM_ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority over fetch.
module riscv_soft_mem_arbiter #(
  parameter int XPR_LEN = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_cache_req_valid,
  output logic               i_cache_req_ready,
  input  logic [XPR_LEN-1:0] i_cache_req_addr,
  output logic               i_cache_resp_valid,
  output logic [XPR_LEN-1:0] i_cache_resp_data,
  input  logic               d_cache_req_valid,
  output logic               d_cache_req_ready,
  input  logic [1:0]         d_cache_req_op,
  input  logic [2:0]         d_cache_req_op_type,
  input  logic [XPR_LEN-1:0] d_cache_req_addr,
  input  logic [XPR_LEN-1:0] d_cache_req_data,
  output logic               d_cache_resp_valid,
  output logic [XPR_LEN-1:0] d_cache_resp_data,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic               mem_req_rw,
  output logic [2:0]         mem_req_type,
  output logic [XPR_LEN-1:0] mem_req_addr,
  output logic [XPR_LEN-1:0] mem_req_data,
  input  logic               mem_resp_valid,
  input  logic [XPR_LEN-1:0] mem_resp_data
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  localparam logic       OWNER_I   = 1'b0;
  localparam logic       OWNER_D   = 1'b1;
  localparam logic [1:0] OP_STORE  = 2'b10;
  localparam logic [2:0] TYPE_WORD = 3'b010;

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic               req_rw_q, req_rw_d;
  logic [2:0]         req_type_q, req_type_d;
  logic [XPR_LEN-1:0] req_addr_q, req_addr_d;
  logic [XPR_LEN-1:0] req_data_q, req_data_d;
  logic               grant_i, grant_d;
  logic               d_is_store;

  assign d_is_store = (d_cache_req_op == OP_STORE);

`ifdef RISCV_SOFT_MEM_ARB_RR_EN
  logic last_owner_q, last_owner_d;

  // On contention the side that was not granted last time wins.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state_q == S_IDLE) begin
      if (d_cache_req_valid && i_cache_req_valid) begin
        grant_d = (last_owner_q == OWNER_I);
        grant_i = !grant_d;
      end else begin
        grant_d = d_cache_req_valid;
        grant_i = i_cache_req_valid;
      end
    end
  end

  always_comb begin
    last_owner_d = last_owner_q;
    if (grant_d)      last_owner_d = OWNER_D;
    else if (grant_i) last_owner_d = OWNER_I;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_owner_q <= OWNER_I;
    else        last_owner_q <= last_owner_d;
  end
`else
  always_comb begin
    grant_d = (state_q == S_IDLE) && d_cache_req_valid;
    grant_i = (state_q == S_IDLE) && i_cache_req_valid && !d_cache_req_valid;
  end
`endif

  always_comb begin
    // NOTE: every _d starts from its _q so no branch leaves a value unassigned and infers a latch.
    state_d    = state_q;
    owner_d    = owner_q;
    req_rw_d   = req_rw_q;
    req_type_d = req_type_q;
    req_addr_d = req_addr_q;
    req_data_d = req_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_d) begin
          owner_d    = OWNER_D;
          req_rw_d   = d_is_store;
          req_type_d = d_cache_req_op_type;
          req_addr_d = d_cache_req_addr;
          req_data_d = d_is_store ? d_cache_req_data : '0;
          state_d    = S_ISSUE;
        end else if (grant_i) begin
          owner_d    = OWNER_I;
          req_rw_d   = 1'b0;
          req_type_d = TYPE_WORD;
          req_addr_d = i_cache_req_addr;
          req_data_d = '0;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: if (mem_req_ready)  state_d = S_WAIT;
      S_WAIT:  if (mem_resp_valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      owner_q    <= OWNER_I;
      req_rw_q   <= 1'b0;
      req_type_q <= '0;
      req_addr_q <= '0;
      req_data_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      req_rw_q   <= req_rw_d;
      req_type_q <= req_type_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
    end
  end

  // Masking with reset keeps a requester from being acknowledged while the arbiter is held in reset.
  assign i_cache_req_ready  = reset && grant_i;
  assign d_cache_req_ready  = reset && grant_d;

  assign mem_req_valid      = (state_q == S_ISSUE);
  assign mem_req_rw         = req_rw_q;
  assign mem_req_type       = req_type_q;
  assign mem_req_addr       = req_addr_q;
  assign mem_req_data       = req_data_q;

  assign i_cache_resp_valid = (state_q == S_WAIT) && mem_resp_valid && (owner_q == OWNER_I);
  assign d_cache_resp_valid = (state_q == S_WAIT) && mem_resp_valid && (owner_q == OWNER_D);
  assign i_cache_resp_data  = mem_resp_data;
  assign d_cache_resp_data  = mem_resp_data;

endmodule

// File: tb/tb_riscv_soft_mem_arbiter.sv
// Scoreboard bench for riscv_soft_mem_arbiter: directed requests push expectations, a monitor checks them.
// Expectations follow RISCV_SOFT_MEM_ARB_RR_EN when the bench is built with that macro.
module tb_riscv_soft_mem_arbiter;

  localparam int XPR_LEN = 32;

  logic               clk = 1'b0;
  logic               reset;
  logic               i_cache_req_valid;
  logic               i_cache_req_ready;
  logic [XPR_LEN-1:0] i_cache_req_addr;
  logic               i_cache_resp_valid;
  logic [XPR_LEN-1:0] i_cache_resp_data;
  logic               d_cache_req_valid;
  logic               d_cache_req_ready;
  logic [1:0]         d_cache_req_op;
  logic [2:0]         d_cache_req_op_type;
  logic [XPR_LEN-1:0] d_cache_req_addr;
  logic [XPR_LEN-1:0] d_cache_req_data;
  logic               d_cache_resp_valid;
  logic [XPR_LEN-1:0] d_cache_resp_data;
  logic               mem_req_valid;
  logic               mem_req_ready;
  logic               mem_req_rw;
  logic [2:0]         mem_req_type;
  logic [XPR_LEN-1:0] mem_req_addr;
  logic [XPR_LEN-1:0] mem_req_data;
  logic               mem_resp_valid;
  logic [XPR_LEN-1:0] mem_resp_data;

  riscv_soft_mem_arbiter #(.XPR_LEN(XPR_LEN)) dut (
    .clk                 (clk),
    .reset               (reset),
    .i_cache_req_valid   (i_cache_req_valid),
    .i_cache_req_ready   (i_cache_req_ready),
    .i_cache_req_addr    (i_cache_req_addr),
    .i_cache_resp_valid  (i_cache_resp_valid),
    .i_cache_resp_data   (i_cache_resp_data),
    .d_cache_req_valid   (d_cache_req_valid),
    .d_cache_req_ready   (d_cache_req_ready),
    .d_cache_req_op      (d_cache_req_op),
    .d_cache_req_op_type (d_cache_req_op_type),
    .d_cache_req_addr    (d_cache_req_addr),
    .d_cache_req_data    (d_cache_req_data),
    .d_cache_resp_valid  (d_cache_resp_valid),
    .d_cache_resp_data   (d_cache_resp_data),
    .mem_req_valid       (mem_req_valid),
    .mem_req_ready       (mem_req_ready),
    .mem_req_rw          (mem_req_rw),
    .mem_req_type        (mem_req_type),
    .mem_req_addr        (mem_req_addr),
    .mem_req_data        (mem_req_data),
    .mem_resp_valid      (mem_resp_valid),
    .mem_resp_data       (mem_resp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic               rw;
    logic [2:0]         typ;
    logic [XPR_LEN-1:0] addr;
    logic [XPR_LEN-1:0] data;
  } mem_exp_t;

  typedef struct {
    logic               is_d;
    logic [XPR_LEN-1:0] data;
  } resp_exp_t;

  mem_exp_t  mem_q[$];
  resp_exp_t resp_q[$];
  mem_exp_t  mon_m;
  resp_exp_t mon_r;
  int        tests = 0;
  int        fails = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req_valid"}, mem_req_valid, 0);
    check({tag, "_i_ready"}, i_cache_req_ready, 0);
    check({tag, "_d_ready"}, d_cache_req_ready, 0);
    check({tag, "_i_resp_valid"}, i_cache_resp_valid, 0);
    check({tag, "_d_resp_valid"}, d_cache_resp_valid, 0);
    check({tag, "_mem_req_rw"}, mem_req_rw, 0);
    check({tag, "_mem_req_type"}, mem_req_type, 0);
    check({tag, "_mem_req_addr"}, mem_req_addr, 0);
    check({tag, "_mem_req_data"}, mem_req_data, 0);
  endtask

  // Monitor: memory-side acceptances and requester responses are compared against the queues.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (mem_req_valid && mem_req_ready) begin
        if (mem_q.size() == 0) check("mem_req_unexpected", 1, 0);
        else begin
          mon_m = mem_q.pop_front();
          check("mem_req_rw", mem_req_rw, mon_m.rw);
          check("mem_req_type", mem_req_type, mon_m.typ);
          check("mem_req_addr", mem_req_addr, mon_m.addr);
          check("mem_req_data", mem_req_data, mon_m.data);
        end
      end
      if (i_cache_resp_valid && d_cache_resp_valid) check("resp_both_valid", 1, 0);
      else if (i_cache_resp_valid || d_cache_resp_valid) begin
        if (resp_q.size() == 0) check("resp_unexpected", 1, 0);
        else begin
          mon_r = resp_q.pop_front();
          check("resp_owner_d", d_cache_resp_valid, mon_r.is_d);
          check("resp_data", mon_r.is_d ? d_cache_resp_data : i_cache_resp_data, mon_r.data);
        end
      end
    end
  end

  task automatic start_i(input logic [31:0] addr);
    i_cache_req_valid = 1'b1;
    i_cache_req_addr  = addr;
  endtask

  task automatic start_d(input logic [1:0] op, input logic [2:0] typ,
                         input logic [31:0] addr, input logic [31:0] data);
    d_cache_req_valid   = 1'b1;
    d_cache_req_op      = op;
    d_cache_req_op_type = typ;
    d_cache_req_addr    = addr;
    d_cache_req_data    = data;
  endtask

  // Runs one transaction from IDLE: grant, ready_delay stalled ISSUE cycles, resp_delay WAIT cycles.
  task automatic txn(input bit exp_d, input int ready_delay, input int resp_delay,
                     input bit spurious, input logic [31:0] rdata);
    mem_exp_t  me;
    resp_exp_t re;
    if (exp_d) begin
      me.rw   = (d_cache_req_op == 2'b10);
      me.typ  = d_cache_req_op_type;
      me.addr = d_cache_req_addr;
      me.data = me.rw ? d_cache_req_data : 32'h0;
    end else begin
      me.rw   = 1'b0;
      me.typ  = 3'b010;
      me.addr = i_cache_req_addr;
      me.data = 32'h0;
    end
    re.is_d = exp_d;
    re.data = rdata;
    mem_q.push_back(me);
    resp_q.push_back(re);
    @(negedge clk);
    check("grant_d_ready", d_cache_req_ready, exp_d);
    check("grant_i_ready", i_cache_req_ready, !exp_d);
    @(posedge clk); #1;
    if (exp_d) d_cache_req_valid = 1'b0;
    else       i_cache_req_valid = 1'b0;
    for (int k = 0; k < ready_delay; k++) begin
      mem_req_ready  = 1'b0;
      mem_resp_valid = spurious;
      mem_resp_data  = 32'hBAD0_0000 | k;
      @(negedge clk);
      check("issue_hold_valid", mem_req_valid, 1);
      check("issue_hold_addr", mem_req_addr, me.addr);
      check("issue_hold_rw", mem_req_rw, me.rw);
      check("issue_hold_data", mem_req_data, me.data);
      check("issue_no_ready", {i_cache_req_ready, d_cache_req_ready}, 0);
      check("issue_no_resp", {i_cache_resp_valid, d_cache_resp_valid}, 0);
      @(posedge clk); #1;
    end
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b1;
    @(negedge clk);
    check("issue_valid", mem_req_valid, 1);
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    for (int k = 0; k < resp_delay; k++) begin
      @(negedge clk);
      check("wait_no_req", mem_req_valid, 0);
      check("wait_no_resp", {i_cache_resp_valid, d_cache_resp_valid}, 0);
      @(posedge clk); #1;
    end
    mem_resp_valid = 1'b1;
    mem_resp_data  = rdata;
    @(negedge clk);
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0F0F_0F0F;
  endtask

  initial begin
    reset               = 1'b0;
    i_cache_req_valid   = 1'b1;
    i_cache_req_addr    = 32'h0000_0040;
    d_cache_req_valid   = 1'b1;
    d_cache_req_op      = 2'b01;
    d_cache_req_op_type = 3'b010;
    d_cache_req_addr    = 32'h0000_0080;
    d_cache_req_data    = 32'h1234_5678;
    mem_req_ready       = 1'b1;
    mem_resp_valid      = 1'b1;
    mem_resp_data       = 32'h0;

    // Reset: everything zero even with both requesters and memory active.
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    reset             = 1'b1;
    i_cache_req_valid = 1'b0;
    d_cache_req_valid = 1'b0;
    mem_req_ready     = 1'b0;
    mem_resp_valid    = 1'b0;

    // Contention: op 2'b11 behaves as a load, store data must not leak.
    start_i(32'h0000_0300);
    start_d(2'b11, 3'b100, 32'h0000_0400, 32'h1111_2222);
    txn(1, 0, 0, 0, 32'hCAFE_0001);
    start_d(2'b10, 3'b001, 32'h0000_0404, 32'h5555_AAAA);
`ifdef RISCV_SOFT_MEM_ARB_RR_EN
    txn(0, 0, 0, 0, 32'h0000_0093);
    txn(1, 1, 0, 0, 32'h0000_0000);
`else
    txn(1, 0, 1, 0, 32'h0000_0000);
    txn(0, 0, 0, 0, 32'h0000_0093);
`endif

    // Fetch only, response two cycles after acceptance.
    start_i(32'h0000_0100);
    txn(0, 0, 2, 0, 32'h0000_0013);

    // Store with three stalled ISSUE cycles and spurious responses while stalled.
    start_d(2'b10, 3'b010, 32'h0000_2000, 32'hDEAD_BEEF);
    txn(1, 3, 1, 1, 32'h0000_0000);

    // Spurious response in IDLE.
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h7777_0001;
    @(negedge clk);
    check("idle_spur_i_resp", i_cache_resp_valid, 0);
    check("idle_spur_d_resp", d_cache_resp_valid, 0);
    check("idle_spur_req", mem_req_valid, 0);
    check("resp_data_mirror", i_cache_resp_data, 32'h7777_0001);
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    start_i(32'h0000_0180);
    txn(0, 0, 0, 0, 32'h0000_0033);

    // Reset during WAIT; the late response must be ignored.
    start_i(32'h0000_0500);
    mem_q.push_back('{rw: 1'b0, typ: 3'b010, addr: 32'h0000_0500, data: 32'h0});
    @(negedge clk);
    check("midop_grant_i", i_cache_req_ready, 1);
    @(posedge clk); #1;
    i_cache_req_valid = 1'b0;
    mem_req_ready     = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    @(negedge clk);
    check("midop_in_wait", mem_req_valid, 0);
    @(posedge clk); #1;
    reset             = 1'b0;
    i_cache_req_valid = 1'b1;
    d_cache_req_valid = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    check_all_zero("held_reset");
    @(posedge clk); #1;
    reset             = 1'b1;
    i_cache_req_valid = 1'b0;
    d_cache_req_valid = 1'b0;
    mem_resp_valid    = 1'b1;
    mem_resp_data     = 32'h0BAD_0BAD;
    @(negedge clk);
    check("late_resp_i", i_cache_resp_valid, 0);
    check("late_resp_d", d_cache_resp_valid, 0);
    check("late_resp_req", mem_req_valid, 0);
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    start_i(32'h0000_0600);
    txn(0, 0, 0, 0, 32'h0000_0073);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mem_q_drained", mem_q.size(), 0);
    check("resp_q_drained", resp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
